rca_pipe_nbits: RTL and testbench
=================================

# rca_pipe_nbits

Pipelined, parametrised ripple-carry adder: an N-bit add is split into STAGES equal chunks, and each chunk ripples through one register stage. The block accepts one operand pair per cycle behind a valid/ready handshake, supports backpressure, and reports unsigned carry-out and signed overflow. It is the clocked successor to the combinational ripple-carry adder, for datapaths where a full N-bit ripple does not meet timing.

## Interface
- N, 8: operand/result width in bits.
- STAGES, 2: number of pipeline stages. N % STAGES must be 0 (elaboration error otherwise). Chunk width W = N/STAGES.
- clk  in  1  single clock; one clock domain; all state on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operand pair a/b/cin is valid.
- in_ready  out  1  block can accept this cycle.
- a  in  N  operand A, two's-complement or unsigned.
- b  in  N  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  s/cout/ovf hold a result.
- out_ready  in  1  consumer accepts the result this cycle.
- s  out  N  sum, low N bits.
- cout  out  1  carry out of bit N-1 (unsigned overflow).
- ovf  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- Stage k (0..STAGES-1) adds chunk k of a/b, bits [kW+W-1:kW], plus the carry registered by stage k-1; stage 0 uses cin. Each chunk is a W-bit ripple of full adders.
- Each stage register holds:
  - finished low sum chunks;
  - not-yet-added high operand chunks;
  - the chunk carry-out;
  - a valid bit v_k.
- Stage k advances when v_k=0 or stage k+1 advances. The last stage advances when out_valid=0 or out_ready=1.
- in_ready = !v_0 || (stage 1 advances); with STAGES=1, in_ready = !out_valid || out_ready. This path is combinational.
- A transfer occurs on in_valid && in_ready at a rising edge. An output transfer occurs on out_valid && out_ready.
- out_valid = v_{STAGES-1}. s, cout and ovf are driven directly from last-stage registers.
- The last stage also registers the carry into bit N-1, for ovf.
- While out_valid && !out_ready, s/cout/ovf hold stable.
- Results leave in acceptance order. Nothing is dropped or duplicated.
- Reset state:
  - all v_k=0 and all data registers 0;
  - so out_valid=0, s=0, cout=0, ovf=0, in_ready=1.
- Reset mid-operation: in-flight transactions are discarded immediately, because the reset is asynchronous. Operation resumes on the first edge after rst_n deasserts.
- Arithmetic is modulo 2^N, with {cout,s} = a + b + cin exactly.

## Timing
- Latency: the accepting edge is edge 1. out_valid is high after edge STAGES, provided there is no stall.
- Throughput: 1 result/cycle with out_ready held high.
- Simultaneous accept and output in the same cycle is legal in every stage; a full pipeline streams without bubbles.
- Capacity: STAGES transactions. With out_ready=0, in_ready falls once all v_k=1.
- The critical path is one W-bit ripple plus the handshake logic.
- in_ready depends combinationally on out_ready through the advance chain. It never depends on in_valid.

## Configuration
- RCA_PIPE_SUB_EN defined:
  - adds port sub (in, 1), sampled with a on acceptance.
  - sub=1 computes a + ~b + 1; cin is ignored.
  - cout=1 means no borrow.
  - ovf uses the same carry-based rule.
  - sub=0 behaves as a plain add with cin.
- RCA_PIPE_SUB_EN undefined: there is no sub port, and the block is add-only.

## Test plan
All scenarios use N=8, STAGES=2 unless stated.
- Accept a=8'h7F, b=8'h01, cin=0 with out_ready=1 -> after 2 edges, out_valid=1, s=8'h80, cout=0, ovf=1.
- Accept a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0. Accept a=8'h0F, b=8'h00, cin=1 -> s=8'h10, chunk carry crossing the stage boundary.
- Stream 4 back-to-back pairs (i, 2i) for i=1..4 with out_ready=1 -> s=3,6,9,12 on 4 consecutive cycles; in_ready stays 1.
- Hold out_ready=0 and offer 3 pairs -> the first 2 are accepted and in_ready=0 on the 3rd. s holds the first result stable. Release out_ready -> all 3 results arrive in order.
- Assert rst_n=0 mid-stream, between clock edges -> out_valid=0 and s=0 immediately, in_ready=1. The first result after reset is the first pair accepted after reset.
- With RCA_PIPE_SUB_EN: a=8'h05, b=8'h07, sub=1 -> s=8'hFE, cout=0, ovf=0. a=8'h80, b=8'h01, sub=1 -> s=8'h7F, cout=1, ovf=1.

Source files
------------

// File: rtl/rca_pipe_nbits.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pipe_nbits
//  Description : Pipelined N-bit ripple-carry adder. The add is cut into
//                STAGES equal chunks of W = N/STAGES bits. Each chunk ripples
//                through its own register stage behind a valid/ready
//                handshake with full backpressure. Produces carry-out and
//                signed overflow.
//  Option      : define RCA_PIPE_SUB_EN to add a 'sub' input
//                (a - b as a + ~b + 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_pipe_nbits #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
`ifdef RCA_PIPE_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (N % STAGES != 0) begin : g_check
        $error("rca_pipe_nbits: N must be a multiple of STAGES");
    end

    // Effective second operand and carry-in once the add/sub choice is applied.
    logic [N-1:0] w_b_eff;
    logic         w_cin_eff;

`ifdef RCA_PIPE_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    // Per-stage valid bits and the advance chain. w_adv[STAGES] is the
    // consumer taking the result. w_adv[k] means stage k's register may load.
    logic [STAGES-1:0] w_v;
    logic [STAGES:0]   w_adv;

    // A stage advances when it is empty or when its successor advances.
    always_comb begin
        w_adv         = '0;
        w_adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = !w_v[k] || w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // LO: sum bits complete after this stage. AW: operand bits entering this stage.
        localparam int LO = (k + 1) * W;
        localparam int AW = N - k * W;

        logic [AW-1:0] w_ain;
        logic [AW-1:0] w_bin;
        logic          w_ci;
        logic          w_vin;
        logic [W:0]    w_c;
        logic [W-1:0]  w_sum_chunk;
        logic [LO-1:0] w_sum_next;
        logic [LO-1:0] r_sum;
        logic          r_co;
        logic          r_v;

        if (k == 0) begin : g_first
            assign w_ain      = a;
            assign w_bin      = w_b_eff;
            assign w_ci       = w_cin_eff;
            assign w_vin      = in_valid;
            assign w_sum_next = w_sum_chunk;
        end else begin : g_next
            logic [AW-1:0] r_ain;
            logic [AW-1:0] r_bin;

            // Carry the not-yet-added high operand chunks alongside the partial sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ain <= '0;
                    r_bin <= '0;
                end else if (w_adv[k-1] && g_stage[k-1].w_vin) begin
                    r_ain <= g_stage[k-1].w_ain[AW+W-1:W];
                    r_bin <= g_stage[k-1].w_bin[AW+W-1:W];
                end
            end

            assign w_ain      = r_ain;
            assign w_bin      = r_bin;
            assign w_ci       = g_stage[k-1].r_co;
            assign w_vin      = g_stage[k-1].r_v;
            assign w_sum_next = {w_sum_chunk, g_stage[k-1].r_sum};
        end

        // W-bit ripple of full adders on the lowest remaining operand chunk.
        always_comb begin
            w_c         = '0;
            w_sum_chunk = '0;
            w_c[0]      = w_ci;
            for (int i = 0; i < W; i++) begin
                w_sum_chunk[i] = w_ain[i] ^ w_bin[i] ^ w_c[i];
                w_c[i+1]       = (w_ain[i] & w_bin[i]) | (w_c[i] & (w_ain[i] ^ w_bin[i]));
            end
        end

        // Stage result register: partial sum, chunk carry-out and valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_sum <= '0;
                r_co  <= 1'b0;
            end else if (w_adv[k]) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_sum <= w_sum_next;
                    r_co  <= w_c[W];
                end
            end
        end

        assign w_v[k] = r_v;
    end

    // Carry into the sign bit, captured by the last stage for overflow.
    logic r_cn1;

    // Capture the carry into bit N-1 with the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cn1 <= 1'b0;
        end else if (w_adv[STAGES-1] && g_stage[STAGES-1].w_vin) begin
            r_cn1 <= g_stage[STAGES-1].w_c[W-1];
        end
    end

    assign out_valid = w_v[STAGES-1];
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_co;
    assign ovf       = g_stage[STAGES-1].r_co ^ r_cn1;

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe_nbits.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_pipe_nbits
//  Description : Self-checking bench for rca_pipe_nbits (N=8, STAGES=2).
//                Arithmetic reference model with in-order result queue plus
//                directed vectors with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_pipe_nbits;

    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub_drv   = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    res_t q[$];
    res_t held;
    logic hold = 1'b0;

    rca_pipe_nbits #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_PIPE_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact (N+1)-bit sum; overflow when both addends share a sign the sum lacks.
    function automatic res_t model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                   input logic ci, input logic sb);
        logic [N:0]   full;
        logic [N-1:0] be;
        logic         cc;
        res_t         r;
        be   = sb ? ~bb : bb;
        cc   = sb ? 1'b1 : ci;
        full = {1'b0, aa} + {1'b0, be} + {{N{1'b0}}, cc};
        r.s  = full[N-1:0];
        r.c  = full[N];
        r.o  = (aa[N-1] == be[N-1]) && (r.s[N-1] != aa[N-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mid-cycle monitor: predicts transfers at the coming edge and scores outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold && out_valid) begin
                chk("hold_s", s, held.s);
                chk("hold_cout", cout, held.c);
                chk("hold_ovf", ovf, held.o);
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub_drv));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got s=%0h expected no output", s);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("model_s", s, e.s);
                    chk("model_cout", cout, e.c);
                    chk("model_ovf", ovf, e.o);
                end
            end
            hold   = out_valid && !out_ready;
            held.s = s;
            held.c = cout;
            held.o = ovf;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One isolated transaction with out_ready high; entered and left at posedge+1.
    task automatic send_one(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                            input logic vs, input logic [7:0] es, input logic ec,
                            input logic eo);
        a = va; b = vb; cin = vc; sub_drv = vs; in_valid = 1'b1;
        #1 chk("one_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("one_latency_valid", out_valid, 0);
        @(posedge clk);
        #1 chk("one_out_valid", out_valid, 1);
        chk("one_s", s, es);
        chk("one_cout", cout, ec);
        chk("one_ovf", ovf, eo);
        sub_drv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single transactions with literal results
        send_one(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send_one(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send_one(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        send_one(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send_one(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
`ifdef RCA_PIPE_SUB_EN
        send_one(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        send_one(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
        idle(1);

        // Back-to-back stream (i, 2i)
        for (int i = 1; i <= 4; i++) begin
            a = 8'(i); b = 8'(2 * i); cin = 1'b0; in_valid = 1'b1;
            #1 chk("stream_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_s", s, 3 * (i - 1));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("stream_valid_last", out_valid, 1);
        chk("stream_s_last", s, 12);
        idle(2);

        // Backpressure: capacity of two, then drain in order
        chk("bp_start_empty", out_valid, 0);
        out_ready = 1'b0;
        a = 8'h10; b = 8'h01; in_valid = 1'b1;
        #1 chk("bp_ready1", in_ready, 1);
        @(posedge clk);
        #1 a = 8'h20; b = 8'h02;
        #1 chk("bp_ready2", in_ready, 1);
        @(posedge clk);
        #1 a = 8'h30; b = 8'h03;
        #1 chk("bp_ready3_full", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_s_first", s, 8'h11);
        @(posedge clk);
        #1 chk("bp_still_full", in_ready, 0);
        chk("bp_s_held", s, 8'h11);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 chk("bp_ready_release", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_valid2", out_valid, 1);
        chk("bp_s_second", s, 8'h22);
        @(posedge clk);
        #1 chk("bp_s_third", s, 8'h33);
        @(posedge clk);
        #1 chk("bp_drained", out_valid, 0);

        // Asynchronous reset in the middle of a stream
        a = 8'h41; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 8'h42;
        @(posedge clk);
        #1 a = 8'h43;
        chk("mid_valid_before", out_valid, 1);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1 chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_s", s, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_cout", cout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_one(8'h55, 8'h11, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0);
        idle(2);

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
